// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master bit engine, 4-wire full duplex / 3-wire half duplex
//
// Serialises one DATA_W-bit word per transaction, MSB first, and returns the
// word captured from the receive line. Every pin-facing output is a flop.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   tx_valid/tx_ready     word handshake; tx_data, tx_rw, four_wire_i latched at accept
//   rx_valid/rx_data      one-cycle completion pulse with the captured word
//   csb_o, sclk_o, mosi_o chip select (low active), serial clock, MOSI / shared IO value
//   mosi_oe               1 = drive the MOSI / shared IO line
//   mosi_i, miso_i        sampled shared IO line (3-wire) and MISO line (4-wire)
//   four_wire_o           latched mode for the pin interface
module spi_master_ctrl #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_rw,
   input  logic              four_wire_i,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              csb_o,
   output logic              sclk_o,
   output logic              mosi_o,
   output logic              mosi_oe,
   input  logic              mosi_i,
   input  logic              miso_i,
   output logic              four_wire_o
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HI,
      S_LO,
      S_HOLD,
      S_GAP
   } state_t;

   state_t             state, state_nx;
   logic [DIV_W-1:0]   div_cnt, div_cnt_nx;
   logic [BIT_W-1:0]   bit_cnt, bit_cnt_nx;
   // MSB is already on mosi_o at accept, so only the remaining bits are kept
   logic [DATA_W-2:0]  tx_shift;
   logic [DATA_W-1:0]  rx_shift;
   logic               rw_q;
   logic               accept;
   logic               div_last;
   logic               enter_hi;
   logic               enter_lo;
   logic               enter_gap;
   logic               rx_bit;
   logic               rd_nx;
   logic               csb_nx;

   assign accept    = tx_valid && tx_ready;
   assign div_last  = (div_cnt == DIV_LAST);
   assign enter_hi  = (state_nx == S_HI)  && (state != S_HI);
   assign enter_lo  = (state_nx == S_LO)  && (state != S_LO);
   assign enter_gap = (state_nx == S_GAP) && (state != S_GAP);
   assign rx_bit    = four_wire_o ? miso_i : mosi_i;
   assign csb_nx    = (state_nx == S_IDLE) || (state_nx == S_GAP);

   // Read mode must be known on the accept edge itself, before the latches update
   assign rd_nx = accept ? (~four_wire_i & tx_rw) : (~four_wire_o & rw_q);

   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      div_cnt_nx = '0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nx   = S_SETUP;
               bit_cnt_nx = '0;
            end
         end
         S_SETUP: if (div_last) state_nx = S_HI;
         S_HI: begin
            if (div_last) begin
               if (bit_cnt == BIT_LAST) begin
                  state_nx = S_HOLD;
               end else begin
                  state_nx   = S_LO;
                  bit_cnt_nx = bit_cnt + 1'b1;
               end
            end
         end
         S_LO:   if (div_last) state_nx = S_HI;
         S_HOLD: if (div_last) state_nx = S_GAP;
         S_GAP:  if (div_last) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      // The divider restarts on every state change so each state lasts CLK_DIV cycles
      if ((state_nx == state) && (state != S_IDLE)) begin
         div_cnt_nx = div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         rw_q     <= 1'b0;
      end else begin
         state   <= state_nx;
         div_cnt <= div_cnt_nx;
         bit_cnt <= bit_cnt_nx;
         if (accept) begin
            tx_shift <= tx_data[DATA_W-2:0];
            rx_shift <= '0;
            rw_q     <= tx_rw;
         end else begin
            if (enter_lo) tx_shift <= tx_shift << 1;
            if (enter_hi) rx_shift <= {rx_shift[DATA_W-2:0], rx_bit};
         end
      end
   end

   // Pin and handshake registers are loaded from the next state, so they line
   // up with the state they describe with no combinational path to the pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csb_o       <= 1'b1;
         sclk_o      <= 1'b0;
         mosi_o      <= 1'b0;
         mosi_oe     <= 1'b0;
         tx_ready    <= 1'b1;
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         four_wire_o <= 1'b0;
      end else begin
         csb_o    <= csb_nx;
         sclk_o   <= (state_nx == S_HI);
         mosi_oe  <= ~csb_nx & ~rd_nx;
         tx_ready <= (state_nx == S_IDLE);
         rx_valid <= enter_gap;
         if (enter_gap) rx_data <= rx_shift;
         if (accept) begin
            mosi_o      <= tx_data[DATA_W-1];
            four_wire_o <= four_wire_i;
         end else if (enter_lo) begin
            // tx_shift shifts on this same edge, so its top bit is the next bit out
            mosi_o <= tx_shift[DATA_W-2];
         end
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] data;
      logic         rw;
      logic         fw;
      logic [W-1:0] slave;
      logic         sel;
      logic [W-1:0] exp_rx;
      logic         exp_oe;
      logic         exp_fw;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         tx_valid;
   logic [W-1:0] tx_data;
   logic         tx_rw;
   logic         four_wire_i;
   logic         sel;
   logic         slave_bit;

   logic         tx_ready0, rx_valid0, csb0, sclk0, mosi0, oe0, fw0, mosi_in0;
   logic [W-1:0] rx_data0;
   logic         tx_ready1, rx_valid1, csb1, sclk1, mosi1, oe1, fw1, mosi_in1;
   logic [W-1:0] rx_data1;

   logic         o_ready, o_rxv, o_csb, o_sclk, o_mosi, o_oe, o_fw;
   logic [W-1:0] o_rxd;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   // Shared IO line: whoever drives it wins; the slave only drives when the master releases
   assign mosi_in0 = oe0 ? mosi0 : slave_bit;
   assign mosi_in1 = oe1 ? mosi1 : slave_bit;

   assign o_ready = sel ? tx_ready1 : tx_ready0;
   assign o_rxv   = sel ? rx_valid1 : rx_valid0;
   assign o_rxd   = sel ? rx_data1  : rx_data0;
   assign o_csb   = sel ? csb1      : csb0;
   assign o_sclk  = sel ? sclk1     : sclk0;
   assign o_mosi  = sel ? mosi1     : mosi0;
   assign o_oe    = sel ? oe1       : oe0;
   assign o_fw    = sel ? fw1       : fw0;

   spi_master_ctrl #(.DATA_W(W), .CLK_DIV(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .tx_valid(tx_valid & ~sel), .tx_ready(tx_ready0),
      .tx_data(tx_data), .tx_rw(tx_rw), .four_wire_i(four_wire_i),
      .rx_valid(rx_valid0), .rx_data(rx_data0),
      .csb_o(csb0), .sclk_o(sclk0), .mosi_o(mosi0), .mosi_oe(oe0),
      .mosi_i(mosi_in0), .miso_i(slave_bit), .four_wire_o(fw0)
   );

   spi_master_ctrl #(.DATA_W(W), .CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .tx_valid(tx_valid & sel), .tx_ready(tx_ready1),
      .tx_data(tx_data), .tx_rw(tx_rw), .four_wire_i(four_wire_i),
      .rx_valid(rx_valid1), .rx_data(rx_data1),
      .csb_o(csb1), .sclk_o(sclk1), .mosi_o(mosi1), .mosi_oe(oe1),
      .mosi_i(mosi_in1), .miso_i(slave_bit), .four_wire_o(fw1)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Word seen on the receive line at the SCLK rising edges
   function automatic logic [W-1:0] model_rx(input logic [W-1:0] data, input logic rw,
                                             input logic fw, input logic [W-1:0] slave);
      if (!fw && !rw) return data;
      return slave;
   endfunction

   task automatic wait_ready();
      int waited;
      waited = 0;
      @(negedge clk);
      while (!o_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("ready_wait", o_ready, 1);
   endtask

   task automatic run_txn(input vec_t v);
      int d, n, rises, first_low, low_cnt, first_rise, last_rise, gap_err, high_cnt;
      int sclk_err, oe_err, fw_err, rxv_cnt, rxv_cyc, rdy_cyc;
      logic [W-1:0] mosi_bits, rx_got;
      logic prev_sclk;
      sel = v.sel;
      d = v.sel ? 1 : 2;
      wait_ready();
      tx_data = v.data; tx_rw = v.rw; four_wire_i = v.fw; tx_valid = 1'b1;
      slave_bit = v.slave[W-1];
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data = W'($urandom); tx_rw = 1'($urandom); four_wire_i = 1'($urandom);
      rises = 0; first_low = -1; low_cnt = 0; first_rise = -1; last_rise = 0; gap_err = 0;
      high_cnt = 0; sclk_err = 0; oe_err = 0; fw_err = 0; rxv_cnt = 0; rxv_cyc = -1;
      rdy_cyc = -1; mosi_bits = '0; rx_got = '0; prev_sclk = 1'b0;
      for (n = 1; n <= 150; n++) begin
         if (!o_csb) begin
            if (first_low < 0) first_low = n;
            low_cnt++;
         end
         if (o_sclk) begin
            high_cnt++;
            if (o_csb) sclk_err++;
         end
         if (o_sclk && !prev_sclk) begin
            if (rises < W) mosi_bits[W-1-rises] = o_mosi;
            if (rises == 0) first_rise = n;
            else if (n - last_rise != 2 * d) gap_err++;
            last_rise = n;
            rises++;
            if (rises < W) slave_bit = v.slave[W-1-rises];
         end
         prev_sclk = o_sclk;
         if (!o_csb) begin
            if (o_oe !== v.exp_oe) oe_err++;
            if (o_fw !== v.exp_fw) fw_err++;
         end else if (o_oe !== 1'b0) begin
            oe_err++;
         end
         if (o_rxv) begin
            rxv_cnt++;
            rxv_cyc = n;
            rx_got = o_rxd;
         end
         if (rxv_cnt > 0 && o_ready) begin
            rdy_cyc = n;
            break;
         end
         @(negedge clk);
      end
      check("csb_fall_cycle", first_low, 1);
      check("csb_low_len", low_cnt, d * (2 * W + 1));
      check("sclk_rises", rises, W);
      check("first_rise_cycle", first_rise, 1 + d);
      check("rise_spacing", gap_err, 0);
      check("sclk_high_cycles", high_cnt, W * d);
      check("sclk_outside_csb", sclk_err, 0);
      if (v.exp_oe) check("mosi_bits", mosi_bits, v.data);
      check("mosi_oe", oe_err, 0);
      check("four_wire_o", fw_err, 0);
      check("rx_valid_count", rxv_cnt, 1);
      check("rx_valid_cycle", rxv_cyc, 1 + d * (2 * W + 1));
      check("rx_data", rx_got, v.exp_rx);
      check("tx_ready_cycle", rdy_cyc, 1 + d * (2 * W + 1) + d);
   endtask

   vec_t vecs [0:16];

   initial begin
      int windows, high_run, min_gap, rxv, rises, csb_low_seen;
      int lens [0:1];
      logic [W-1:0] rxs [0:1];
      logic prev_csb, prev_sclk, hit;

      rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_rw = 1'b0; four_wire_i = 1'b0;
      sel = 1'b0; slave_bit = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_csb", csb0, 1);
      check("rst_sclk", sclk0, 0);
      check("rst_mosi", mosi0, 0);
      check("rst_oe", oe0, 0);
      check("rst_ready", tx_ready0, 1);
      check("rst_rx_valid", rx_valid0, 0);
      check("rst_rx_data", rx_data0, 0);
      check("rst_four_wire", fw0, 0);
      rst_n = 1'b1;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b1};
      vecs[1] = '{8'h00, 1'b1, 1'b0, 8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0};
      vecs[2] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b1, 1'b0};
      vecs[3] = '{8'h81, 1'b1, 1'b1, 8'h7E, 1'b0, 8'h7E, 1'b1, 1'b1};
      vecs[4] = '{8'hA5, 1'b0, 1'b1, 8'h96, 1'b1, 8'h96, 1'b1, 1'b1};
      for (int i = 5; i <= 16; i++) begin
         vecs[i].data  = W'($urandom);
         vecs[i].rw    = 1'($urandom_range(0, 1));
         vecs[i].fw    = 1'($urandom_range(0, 1));
         vecs[i].slave = W'($urandom);
         vecs[i].sel   = 1'($urandom_range(0, 1));
         vecs[i].exp_rx = model_rx(vecs[i].data, vecs[i].rw, vecs[i].fw, vecs[i].slave);
         vecs[i].exp_oe = vecs[i].fw | ~vecs[i].rw;
         vecs[i].exp_fw = vecs[i].fw;
      end
      for (int i = 0; i <= 16; i++) run_txn(vecs[i]);

      // Back-to-back: tx_valid held high across two 3-wire loopback writes
      sel = 1'b0;
      wait_ready();
      tx_data = 8'h01; tx_rw = 1'b0; four_wire_i = 1'b0; tx_valid = 1'b1;
      windows = 0; high_run = 0; min_gap = 1000; rxv = 0; prev_csb = 1'b1;
      lens[0] = 0; lens[1] = 0; rxs[0] = '0; rxs[1] = '0;
      for (int n = 0; n < 120; n++) begin
         @(negedge clk);
         if (!o_csb) begin
            if (prev_csb) begin
               windows++;
               if (windows > 1 && high_run < min_gap) min_gap = high_run;
               if (windows == 1) tx_data = 8'hFF;
               if (windows == 2) tx_valid = 1'b0;
            end
            if (windows >= 1 && windows <= 2) lens[windows-1]++;
            high_run = 0;
         end else begin
            high_run++;
         end
         prev_csb = o_csb;
         if (o_rxv) begin
            if (rxv < 2) rxs[rxv] = o_rxd;
            rxv++;
         end
      end
      tx_valid = 1'b0;
      check("b2b_windows", windows, 2);
      check("b2b_len0", lens[0], 34);
      check("b2b_len1", lens[1], 34);
      check("b2b_min_gap", min_gap, 3);
      check("b2b_rx_count", rxv, 2);
      check("b2b_rx0", rxs[0], 8'h01);
      check("b2b_rx1", rxs[1], 8'hFF);

      // Asynchronous reset at the 4th SCLK rising edge
      sel = 1'b0;
      wait_ready();
      tx_data = 8'hC6; tx_rw = 1'b0; four_wire_i = 1'b1; tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      rises = 0; prev_sclk = 1'b0; hit = 1'b0;
      for (int n = 0; n < 100 && !hit; n++) begin
         if (o_sclk && !prev_sclk) rises++;
         prev_sclk = o_sclk;
         if (rises == 4) hit = 1'b1;
         else @(negedge clk);
      end
      check("rst_reached_rise4", hit, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_csb", csb0, 1);
      check("mid_rst_sclk", sclk0, 0);
      check("mid_rst_oe", oe0, 0);
      check("mid_rst_ready", tx_ready0, 1);
      check("mid_rst_rx_valid", rx_valid0, 0);
      check("mid_rst_rx_data", rx_data0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rxv = 0; csb_low_seen = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (rx_valid0) rxv++;
         if (!csb0) csb_low_seen++;
      end
      check("post_rst_rx_valid", rxv, 0);
      check("post_rst_csb_low", csb_low_seen, 0);
      run_txn(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Bit-level SPI master engine that drives the pad-facing SPI interface (chip select, serial clock, MOSI/shared IO, MISO) from a parallel word handshake. It accepts one DATA_W-bit word per transaction, serialises it MSB-first in SPI mode 0 and returns the captured receive word. It supports 4-wire full duplex and 3-wire half duplex, where MOSI is the shared IO and is released for reads. It sits directly upstream of the SPI pin interface and produces its csb/sclk/mosi values, the MOSI output enable and the four_wire select.

## Interface
- DATA_W, 8, bits per transaction (≥2)
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1)

- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- tx_valid  in  1  transaction request
- tx_ready  out  1  engine idle, request may be accepted
- tx_data  in  DATA_W  word to shift out, MSB first
- tx_rw  in  1  3-wire only: 1 = read (release MOSI), 0 = write
- four_wire_i  in  1  mode select, latched at accept
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_data  out  DATA_W  captured word, MSB first
- csb_o  out  1  chip select, active low
- sclk_o  out  1  serial clock, idles low
- mosi_o  out  1  MOSI / shared IO drive value
- mosi_oe  out  1  1 = drive MOSI line, 0 = release
- mosi_i  in  1  sampled shared-IO line (3-wire read data)
- miso_i  in  1  sampled MISO line (4-wire read data)
- four_wire_o  out  1  latched mode, to interface four_wire

## Operation
- Reset values: csb_o=1, sclk_o=0, mosi_o=0, mosi_oe=0, tx_ready=1, rx_valid=0, rx_data=0, four_wire_o=0, FSM=IDLE, counters 0.
- The asynchronous reset asserts mid-transaction and immediately forces all reset values, with no completion pulse. The transaction is lost.
- Accept: tx_valid & tx_ready on a rising edge. tx_data, tx_rw and four_wire_i are latched. Later changes to these inputs are ignored until the next accept.
- Read mode is rd = ~four_wire & tx_rw.
  - mosi_oe = ~rd while csb_o=0.
  - mosi_oe = 0 outside a transaction.
- Receive source is miso_i if four_wire, otherwise mosi_i.
  - A 3-wire write (rd=0) still captures mosi_i, which acts as a loopback of the driven bits.
- FSM states: IDLE → SETUP → (HI ↔ LO)* → HOLD → GAP → IDLE. The divider counter runs 0..CLK_DIV-1, and each state except IDLE lasts exactly CLK_DIV cycles.
  - IDLE: csb_o=1, sclk_o=0, tx_ready=1. On accept, go to SETUP.
  - SETUP: csb_o=0, sclk_o=0, mosi_o=bit DATA_W-1. Then go to HI.
  - HI: sclk_o=1. The receive bit is shifted into the LSB of the rx shift register on the edge entering HI. If bits remain, go to LO; after the DATA_W-th HI, go to HOLD.
  - LO: sclk_o=0. mosi_o advances to the next lower bit on the edge entering LO. Then go to HI.
  - HOLD: csb_o=0, sclk_o=0. mosi_o holds the last bit.
  - GAP: csb_o=1, mosi_oe=0, tx_ready=0. On the edge entering GAP, rx_data is loaded and rx_valid=1 for one cycle. Then go to IDLE.
- Exactly DATA_W SCLK rising edges occur per transaction. sclk_o only toggles while csb_o=0.
- All pin outputs are registered, so no combinational path exists from inputs to pins.

## Timing
- The accept edge is cycle 0. csb_o falls at cycle 1 and stays low for CLK_DIV·(2·DATA_W+1) cycles.
- rx_valid is asserted in cycle 1+CLK_DIV·(2·DATA_W+1).
- tx_ready reasserts CLK_DIV cycles after rx_valid. The minimum csb-high gap is therefore CLK_DIV+1 cycles.
- First SCLK rising edge at cycle 1+CLK_DIV. Each subsequent rising edge follows 2·CLK_DIV cycles later.
- MOSI changes only on SCLK falling edges (or at csb fall), giving a half-period of setup before each rising edge.
- tx_valid held high in GAP waits; it is accepted on the first IDLE cycle. Back-to-back transactions never merge chip-select windows.

## Test plan
- 4-wire, DATA_W=8, CLK_DIV=2: tx_data=0xA5 with the slave model returning 0x3C on miso_i → mosi_o bits 1,0,1,0,0,1,0,1 at rising edges; csb_o low for 34 cycles; rx_valid at cycle 35 with rx_data=0x3C; mosi_oe=1 throughout.
- 3-wire read (four_wire_i=0, tx_rw=1), slave driving 0xC3 on mosi_i → mosi_oe=0 for the whole transaction; rx_data=0xC3; four_wire_o=0.
- 3-wire write, tx_data=0x5A with mosi_i looped from mosi_o → mosi_oe=1 while csb_o=0; rx_data=0x5A.
- tx_valid held high with two words 0x01 and 0xFF → two separate csb_o windows, each 34 cycles low; csb_o high for ≥3 cycles between them; two rx_valid pulses.
- rst_n pulsed low at the 4th SCLK rising edge → csb_o=1, sclk_o=0 and mosi_oe=0 immediately; no rx_valid; tx_ready=1; the next transaction completes normally.
- CLK_DIV=1, DATA_W=8: sclk_o toggles every cycle; csb_o low for 17 cycles; rx_valid at cycle 18.
